// File: rtl/stack_pkg.sv
// Shared encodings for the page-1 stack sequencer: command op-codes, FSM states,
// stack page and default stack pointer, plus small op decode helpers.
package stack_pkg;

    typedef enum logic [2:0] {
        OP_PUSH1  = 3'd0,
        OP_PUSH2  = 3'd1,
        OP_PUSH3  = 3'd2,
        OP_PULL1  = 3'd3,
        OP_PULL2  = 3'd4,
        OP_PULL3  = 3'd5,
        OP_LOAD_S = 3'd6,
        OP_NOP    = 3'd7
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_XFER = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    localparam logic [7:0] STACK_PAGE = 8'h01;
    localparam logic [7:0] SP_DEFAULT = 8'hFF;

    // PUSH1..PULL3 move one to three bytes over the stack bus.
    function automatic logic op_is_xfer(input logic [2:0] op);
        return (op <= 3'd5);
    endfunction

    function automatic logic op_is_pull(input logic [2:0] op);
        return (op >= 3'd3) && (op <= 3'd5);
    endfunction

    function automatic logic [1:0] op_bytes(input logic [2:0] op);
        logic [1:0] n;
        case (op)
            3'd0, 3'd3: n = 2'd1;
            3'd1, 3'd4: n = 2'd2;
            3'd2, 3'd5: n = 2'd3;
            default:    n = 2'd0;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/sp_counter.sv
// 8-bit stack pointer register: falling-edge clocked, clock-enabled load/inc/dec,
// asynchronous active-low reset to SP_RESET. Load wins over inc, inc over dec.
module sp_counter
    import stack_pkg::*;
#(
    parameter logic [7:0] SP_RESET = SP_DEFAULT
) (
    input  logic       i_clk,
    input  logic       i_reset_n,
    input  logic       i_clk_en,
    input  logic       i_load,
    input  logic       i_inc,
    input  logic       i_dec,
    input  logic [7:0] i_data,
    output logic [7:0] o_sp
);

    logic [7:0] r_sp;

    always_ff @(negedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_sp <= SP_RESET;
        end else if (i_clk_en) begin
            if (i_load) begin
                r_sp <= i_data;
            end else if (i_inc) begin
                r_sp <= r_sp + 8'd1;
            end else if (i_dec) begin
                r_sp <= r_sp - 8'd1;
            end
        end
    end

    assign o_sp = r_sp;

endmodule

// File: rtl/stack_sequencer.sv
// Page-1 stack bus sequencer: accepts PUSHn/PULLn/LOAD_S/NOP in IDLE, runs n byte
// cycles in XFER and pulses o_done for one cycle. All state moves on falling edges.
module stack_sequencer
    import stack_pkg::*;
#(
    parameter logic [7:0] SP_RESET = SP_DEFAULT
) (
    input  logic        i_clk,
    input  logic        i_reset_n,
    input  logic        i_clk_en,
    input  logic        i_cmd_valid,
    input  logic [2:0]  i_cmd_op,
    input  logic [7:0]  i_data,
    output logic        o_cmd_ready,
    output logic        o_bus_valid,
    output logic        o_rw,
    output logic [15:0] o_addr,
    output logic        o_done,
    output logic [7:0]  o_sp,
    output logic [1:0]  o_dbg_state
);

    // Handshake: a command transfers on an enabled falling edge where
    // i_cmd_valid=1 and o_cmd_ready=1 (IDLE only); valid outside IDLE is dropped.
    state_e     r_state;
    logic [1:0] r_cnt;
    logic       r_pull;
    logic       r_cmd_ready;
    logic       r_bus_valid;
    logic       r_rw;
    logic       r_done;

    logic       w_accept;
    logic       w_load;
    logic       w_inc;
    logic       w_dec;
    logic [7:0] w_sp;

    assign w_accept = i_clk_en && (r_state == ST_IDLE) && i_cmd_valid;
    assign w_load   = w_accept && (i_cmd_op == OP_LOAD_S);
    assign w_inc    = (r_state == ST_XFER) && r_pull;
    assign w_dec    = (r_state == ST_XFER) && !r_pull;

    sp_counter #(
        .SP_RESET (SP_RESET)
    ) u_sp_counter (
        .i_clk     (i_clk),
        .i_reset_n (i_reset_n),
        .i_clk_en  (i_clk_en),
        .i_load    (w_load),
        .i_inc     (w_inc),
        .i_dec     (w_dec),
        .i_data    (i_data),
        .o_sp      (w_sp)
    );

    always_ff @(negedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state     <= ST_IDLE;
            r_cnt       <= 2'd0;
            r_pull      <= 1'b0;
            r_cmd_ready <= 1'b1;
            r_bus_valid <= 1'b0;
            r_rw        <= 1'b1;
            r_done      <= 1'b0;
        end else if (i_clk_en) begin
            case (r_state)
                ST_IDLE: begin
                    if (i_cmd_valid) begin
                        r_cmd_ready <= 1'b0;
                        if (op_is_xfer(i_cmd_op)) begin
                            r_state     <= ST_XFER;
                            r_cnt       <= op_bytes(i_cmd_op);
                            r_pull      <= op_is_pull(i_cmd_op);
                            r_bus_valid <= 1'b1;
                            r_rw        <= op_is_pull(i_cmd_op);
                        end else begin
                            r_state <= ST_DONE;
                            r_done  <= 1'b1;
                        end
                    end
                end
                ST_XFER: begin
                    r_cnt <= r_cnt - 2'd1;
                    if (r_cnt == 2'd1) begin
                        r_state     <= ST_DONE;
                        r_bus_valid <= 1'b0;
                        r_rw        <= 1'b1;
                        r_done      <= 1'b1;
                    end
                end
                ST_DONE: begin
                    r_state     <= ST_IDLE;
                    r_done      <= 1'b0;
                    r_cmd_ready <= 1'b1;
                end
                default: begin
                    r_state     <= ST_IDLE;
                    r_bus_valid <= 1'b0;
                    r_rw        <= 1'b1;
                    r_done      <= 1'b0;
                    r_cmd_ready <= 1'b1;
                end
            endcase
        end
    end

    // Pulls read the byte above S (S+1); pushes write at S. Page byte is fixed.
    assign o_addr      = {STACK_PAGE, (r_bus_valid && r_pull) ? (w_sp + 8'd1) : w_sp};
    assign o_cmd_ready = r_cmd_ready;
    assign o_bus_valid = r_bus_valid;
    assign o_rw        = r_rw;
    assign o_done      = r_done;
    assign o_sp        = w_sp;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_stack_sequencer.sv
// Directed bench for stack_sequencer: a vector table of single commands plus
// hand-written sequences for clock-enable stalls, held valid and mid-transfer reset.
module tb_stack_sequencer;

    logic        i_clk;
    logic        i_reset_n;
    logic        i_clk_en;
    logic        i_cmd_valid;
    logic [2:0]  i_cmd_op;
    logic [7:0]  i_data;
    logic        o_cmd_ready;
    logic        o_bus_valid;
    logic        o_rw;
    logic [15:0] o_addr;
    logic        o_done;
    logic [7:0]  o_sp;
    logic [1:0]  o_dbg_state;

    int n_cmp  = 0;
    int n_fail = 0;

    stack_sequencer #(
        .SP_RESET (8'hFF)
    ) dut (
        .i_clk       (i_clk),
        .i_reset_n   (i_reset_n),
        .i_clk_en    (i_clk_en),
        .i_cmd_valid (i_cmd_valid),
        .i_cmd_op    (i_cmd_op),
        .i_data      (i_data),
        .o_cmd_ready (o_cmd_ready),
        .o_bus_valid (o_bus_valid),
        .o_rw        (o_rw),
        .o_addr      (o_addr),
        .o_done      (o_done),
        .o_sp        (o_sp),
        .o_dbg_state (o_dbg_state)
    );

    // ---- clock / reset: active edge is the falling edge; sample after rising edge
    initial begin
        i_clk = 1'b1;
        forever #5 i_clk = ~i_clk;
    end

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_idle(input string tag, input logic [7:0] sp);
        check({tag, " ready"}, 16'(o_cmd_ready), 16'd1);
        check({tag, " bus_valid"}, 16'(o_bus_valid), 16'd0);
        check({tag, " rw"}, 16'(o_rw), 16'd1);
        check({tag, " done"}, 16'(o_done), 16'd0);
        check({tag, " sp"}, 16'(o_sp), 16'(sp));
        check({tag, " addr"}, o_addr, {8'h01, sp});
        check({tag, " state"}, 16'(o_dbg_state), 16'd0);
    endtask

    // ---- driver: present one command for one enabled edge, then scramble inputs
    task automatic issue(input logic [2:0] op, input logic [7:0] data);
        i_cmd_valid = 1'b1;
        i_cmd_op    = op;
        i_data      = data;
        tick();
        i_cmd_valid = 1'b0;
        i_cmd_op    = 3'($urandom_range(0, 7));
        i_data      = 8'($urandom_range(0, 255));
    endtask

    task automatic load_s(input logic [7:0] v);
        issue(3'd6, v);
        check("load done", 16'(o_done), 16'd1);
        check("load sp", 16'(o_sp), 16'(v));
        tick();
        check_idle("after load", v);
    endtask

    typedef struct {
        string      name;
        logic [7:0] init_s;
        logic [2:0] op;
        int         n;
        logic [15:0] a0;
        logic [15:0] a1;
        logic [15:0] a2;
        logic       rw;
        logic [7:0] final_sp;
    } vec_t;

    vec_t vecs[7];

    initial begin
        logic [15:0] exp_a[3];

        vecs[0] = '{"push2 ff", 8'hFF, 3'd1, 2, 16'h01FF, 16'h01FE, 16'h0000, 1'b0, 8'hFD};
        vecs[1] = '{"push3 01", 8'h01, 3'd2, 3, 16'h0101, 16'h0100, 16'h01FF, 1'b0, 8'hFE};
        vecs[2] = '{"pull3 fe", 8'hFE, 3'd5, 3, 16'h01FF, 16'h0100, 16'h0101, 1'b1, 8'h01};
        vecs[3] = '{"push1 00", 8'h00, 3'd0, 1, 16'h0100, 16'h0000, 16'h0000, 1'b0, 8'hFF};
        vecs[4] = '{"pull1 ff", 8'hFF, 3'd3, 1, 16'h0100, 16'h0000, 16'h0000, 1'b1, 8'h00};
        vecs[5] = '{"pull2 80", 8'h80, 3'd4, 2, 16'h0181, 16'h0182, 16'h0000, 1'b1, 8'h82};
        vecs[6] = '{"nop 10",   8'h10, 3'd7, 0, 16'h0000, 16'h0000, 16'h0000, 1'b1, 8'h10};

        i_reset_n   = 1'b0;
        i_clk_en    = 1'b1;
        i_cmd_valid = 1'b0;
        i_cmd_op    = 3'd7;
        i_data      = 8'h00;
        tick();
        tick();
        check_idle("reset", 8'hFF);
        i_reset_n = 1'b1;
        tick();
        check_idle("post reset", 8'hFF);

        // Reset S is FF: first push addresses 0x01FF without any LOAD_S.
        issue(3'd1, 8'h00);
        check("r push2 a0", o_addr, 16'h01FF);
        check("r push2 rw", 16'(o_rw), 16'd0);
        tick();
        check("r push2 a1", o_addr, 16'h01FE);
        tick();
        check("r push2 done", 16'(o_done), 16'd1);
        check("r push2 sp", 16'(o_sp), 16'h00FD);
        tick();
        check_idle("r push2 idle", 8'hFD);

        // ---- table-driven single commands
        for (int i = 0; i < 7; i++) begin
            load_s(vecs[i].init_s);
            exp_a[0] = vecs[i].a0;
            exp_a[1] = vecs[i].a1;
            exp_a[2] = vecs[i].a2;
            issue(vecs[i].op, 8'h5A);
            for (int k = 0; k < vecs[i].n; k++) begin
                check({vecs[i].name, " bus_valid"}, 16'(o_bus_valid), 16'd1);
                check({vecs[i].name, " addr"}, o_addr, exp_a[k]);
                check({vecs[i].name, " rw"}, 16'(o_rw), 16'(vecs[i].rw));
                check({vecs[i].name, " ready"}, 16'(o_cmd_ready), 16'd0);
                check({vecs[i].name, " done low"}, 16'(o_done), 16'd0);
                tick();
            end
            check({vecs[i].name, " done"}, 16'(o_done), 16'd1);
            check({vecs[i].name, " done bus"}, 16'(o_bus_valid), 16'd0);
            check({vecs[i].name, " done ready"}, 16'(o_cmd_ready), 16'd0);
            check({vecs[i].name, " final sp"}, 16'(o_sp), 16'(vecs[i].final_sp));
            tick();
            check_idle({vecs[i].name, " idle"}, vecs[i].final_sp);
        end

        // ---- clock-enable low in IDLE: command must not be taken
        i_clk_en    = 1'b0;
        i_cmd_valid = 1'b1;
        i_cmd_op    = 3'd0;
        tick();
        tick();
        i_cmd_valid = 1'b0;
        i_clk_en    = 1'b1;
        check_idle("en low idle", 8'h10);

        // ---- PULL1 from FF stretched by three disabled edges
        load_s(8'hFF);
        issue(3'd3, 8'h00);
        check("stall a0", o_addr, 16'h0100);
        i_clk_en = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            check("stall bus", 16'(o_bus_valid), 16'd1);
            check("stall addr", o_addr, 16'h0100);
            check("stall rw", 16'(o_rw), 16'd1);
            check("stall sp", 16'(o_sp), 16'h00FF);
            check("stall done", 16'(o_done), 16'd0);
        end
        i_clk_en = 1'b1;
        tick();
        check("stall done1", 16'(o_done), 16'd1);
        check("stall sp00", 16'(o_sp), 16'h0000);
        i_clk_en = 1'b0;
        tick();
        check("stall done held", 16'(o_done), 16'd1);
        i_clk_en = 1'b1;
        tick();
        check_idle("stall idle", 8'h00);
        tick();
        check("stall one done", 16'(o_done), 16'd0);

        // ---- i_cmd_valid held high across PUSH1: next command only at IDLE
        load_s(8'h50);
        i_cmd_valid = 1'b1;
        i_cmd_op    = 3'd0;
        tick();
        check("hold x1 addr", o_addr, 16'h0150);
        check("hold x1 bus", 16'(o_bus_valid), 16'd1);
        tick();
        check("hold d1 done", 16'(o_done), 16'd1);
        check("hold d1 sp", 16'(o_sp), 16'h004F);
        tick();
        check_idle("hold idle", 8'h4F);
        tick();
        check("hold x2 addr", o_addr, 16'h014F);
        check("hold x2 bus", 16'(o_bus_valid), 16'd1);
        i_cmd_valid = 1'b0;
        tick();
        check("hold d2 done", 16'(o_done), 16'd1);
        check("hold d2 sp", 16'(o_sp), 16'h004E);
        tick();
        check_idle("hold idle2", 8'h4E);
        tick();
        check_idle("hold no third", 8'h4E);

        // ---- reset asserted during the second byte of PUSH3
        load_s(8'hFF);
        issue(3'd2, 8'h00);
        check("rst x1 addr", o_addr, 16'h01FF);
        tick();
        check("rst x2 addr", o_addr, 16'h01FE);
        check("rst x2 sp", 16'(o_sp), 16'h00FE);
        i_reset_n = 1'b0;
        #1;
        check_idle("rst async", 8'hFF);
        tick();
        i_reset_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            check_idle("rst no done", 8'hFF);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
